decodifica_hamming: RTL and testbench

Pipelined Hamming(15,11) decoder/corrector that consumes the 15-bit codewords produced by the team's Hamming encoder stage and returns the 11 data bits. A single-bit error anywhere in the codeword is corrected. Each word also carries a syndrome and an error flag, and a saturating counter tracks corrected words. Valid/ready handshakes sit on both sides, and the block runs at one word per clock when it is not back-pressured.

---
 rtl/hamming_pkg.sv | 42 ++++
 rtl/sindrome_hamming.sv | 18 +
 rtl/decodifica_hamming.sv | 103 ++++++++++
 tb/tb_decodifica_hamming.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) constants and helpers used by both the encoder and decoder stages.
// Codeword bit c[i] is Hamming position i+1.
package hamming_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 15;
  localparam int SYN_W  = 4;

  localparam int PARITY_POS [4]      = '{0, 1, 3, 7};
  localparam int DATA_POS   [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

  // Gathers d1..d11 out of a codeword into a packed data word, d1 in bit 0.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] data;
    data = '0;
    for (int k = 0; k < DATA_W; k++) begin
      data[k] = code[DATA_POS[k]];
    end
    return data;
  endfunction

  // Gathers the four check bits; kept beside extract_data so both stages share one layout.
  function automatic logic [SYN_W-1:0] extract_parity(input logic [CODE_W-1:0] code);
    logic [SYN_W-1:0] par;
    par = '0;
    for (int k = 0; k < SYN_W; k++) begin
      par[k] = code[PARITY_POS[k]];
    end
    return par;
  endfunction

  // One-hot mask selecting the bit named by a syndrome; zero syndrome selects nothing.
  function automatic logic [CODE_W-1:0] flip_mask(input logic [SYN_W-1:0] syn);
    logic [CODE_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < CODE_W; i++) begin
      mask[i] = (syn == SYN_W'(i + 1));
    end
    return mask;
  endfunction

endpackage

// File: rtl/sindrome_hamming.sv
// Combinational Hamming(15,11) syndrome: XOR of the positions of every set bit.
module sindrome_hamming
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SYN_W-1:0]  syn_o
);

  always_comb begin
    syn_o = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (code_i[i]) begin
        syn_o = syn_o ^ SYN_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/decodifica_hamming.sv
// Two-stage pipelined Hamming(15,11) decoder with valid/ready on both sides
// and a saturating count of corrected words delivered downstream.
module decodifica_hamming
  import hamming_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CODE_W-1:0]  entrada,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  saida,
  output logic               erro_corrigido,
  output logic [SYN_W-1:0]   sindrome,
  input  logic               clr_cont,
  output logic [COUNT_W-1:0] cont_erros
);

  logic              s1_valid_q;
  logic [CODE_W-1:0] s1_code_q;
  logic [SYN_W-1:0]  s1_syn_q;

  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_data_q;
  logic              s2_erro_q;
  logic [SYN_W-1:0]  s2_syn_q;

  logic [COUNT_W-1:0] cont_q, cont_d;

  logic [SYN_W-1:0]  syn_d;
  logic [DATA_W-1:0] data_d;
  logic              s1_load, s2_load, out_fire;

  sindrome_hamming u_sindrome (
    .code_i (entrada),
    .syn_o  (syn_d)
  );

  assign data_d   = extract_data(s1_code_q ^ flip_mask(s1_syn_q));

  // S2 frees up on the same edge it hands off, so out_ready reaches in_ready combinationally.
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign s1_load  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    cont_d = cont_q;
    if (clr_cont) begin
      cont_d = '0;
    end else if (out_fire && s2_erro_q && (cont_q != {COUNT_W{1'b1}})) begin
      cont_d = cont_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
    end else if (s1_load) begin
      s1_valid_q <= 1'b1;
      s1_code_q  <= entrada;
      s1_syn_q   <= syn_d;
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_erro_q  <= 1'b0;
      s2_syn_q   <= '0;
    end else if (s2_load) begin
      s2_valid_q <= 1'b1;
      s2_data_q  <= data_d;
      s2_erro_q  <= (s1_syn_q != '0);
      s2_syn_q   <= s1_syn_q;
    end else if (out_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign out_valid      = s2_valid_q;
  assign saida          = s2_data_q;
  assign erro_corrigido = s2_erro_q;
  assign sindrome       = s2_syn_q;
  assign cont_erros     = cont_q;

endmodule

// File: tb/tb_decodifica_hamming.sv
// Directed bench for decodifica_hamming with a 2-bit counter so saturation is reachable.
module tb_decodifica_hamming;
  import hamming_pkg::*;

  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CODE_W-1:0] entrada = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] saida;
  logic              erro_corrigido;
  logic [SYN_W-1:0]  sindrome;
  logic              clr_cont = 1'b0;
  logic [CW-1:0]     cont_erros;

  int total = 0;
  int bad   = 0;

  decodifica_hamming #(.COUNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .entrada        (entrada),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .saida          (saida),
    .erro_corrigido (erro_corrigido),
    .sindrome       (sindrome),
    .clr_cont       (clr_cont),
    .cont_erros     (cont_erros)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one codeword and returns one tick after the edge that accepted it.
  task automatic applyStimulus(input logic [CODE_W-1:0] code);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    entrada  = code;
    #1;
    while (!in_ready && waited < 20) begin
      step();
      #1;
      waited++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // One word through an idle pipe: check the S2 contents, then let it leave.
  task automatic runWord(input string tag, input logic [CODE_W-1:0] code,
                         input logic [DATA_W-1:0] expData, input logic [SYN_W-1:0] expSyn,
                         input logic expErr);
    applyStimulus(code);
    step();
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_saida"}, 32'(saida), 32'(expData));
    checkOutput({tag, "_sind"},  32'(sindrome), 32'(expSyn));
    checkOutput({tag, "_erro"},  32'(erro_corrigido), 32'(expErr));
    step();
  endtask

  logic [CODE_W-1:0] bpWords [4] = '{15'h7FFF, 15'h0006, 15'h408B, 15'h0181};
  logic [DATA_W-1:0] bpData  [4] = '{11'h7FF, 11'h001, 11'h400, 11'h010};

  initial begin
    int acc, outIdx, stale, cyc;
    logic accept;

    #2;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_saida",     32'(saida), 32'd0);
    checkOutput("rst_erro",      32'(erro_corrigido), 32'd0);
    checkOutput("rst_sind",      32'(sindrome), 32'd0);
    checkOutput("rst_cont",      32'(cont_erros), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    runWord("clean",  15'h7FFF, 11'h7FF, 4'd0,  1'b0);
    checkOutput("cont_clean", 32'(cont_erros), 32'd0);
    runWord("err_c4", 15'h7FEF, 11'h7FF, 4'd5,  1'b1);
    checkOutput("cont_1", 32'(cont_erros), 32'd1);
    runWord("par_c0", 15'h0006, 11'h001, 4'd1,  1'b1);
    runWord("pos15",  15'h4007, 11'h001, 4'd15, 1'b1);
    checkOutput("cont_3", 32'(cont_erros), 32'd3);
    runWord("d11_ok", 15'h408B, 11'h400, 4'd0,  1'b0);
    runWord("err_c8", 15'h418B, 11'h400, 4'd9,  1'b1);
    runWord("d5_par", 15'h0180, 11'h010, 4'd1,  1'b1);
    checkOutput("cont_sat", 32'(cont_erros), 32'd3);

    // Sixth erroneous word: clear lands on the same edge as its handshake.
    applyStimulus(15'h7FEF);
    step();
    checkOutput("clr_pre_valid", 32'(out_valid), 32'd1);
    clr_cont = 1'b1;
    step();
    clr_cont = 1'b0;
    checkOutput("clr_prio", 32'(cont_erros), 32'd0);
    step();

    // Backpressure: three stalled cycles, then drain in order.
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      entrada  = bpWords[acc];
      #1;
      accept = in_ready;
      if (c == 2) checkOutput("stall_saida_a", 32'(saida), 32'h7FF);
      @(posedge clk);
      if (accept) acc++;
      #1;
    end
    checkOutput("bp_accepted",   32'(acc), 32'd2);
    checkOutput("bp_in_ready",   32'(in_ready), 32'd0);
    checkOutput("stall_valid",   32'(out_valid), 32'd1);
    checkOutput("stall_saida_b", 32'(saida), 32'h7FF);
    out_ready = 1'b1;
    #1;
    checkOutput("recover_ready", 32'(in_ready), 32'd1);
    outIdx = 0;
    cyc = 0;
    while (outIdx < 4 && cyc < 30) begin
      in_valid = (acc < 4);
      if (acc < 4) entrada = bpWords[acc];
      #1;
      if (out_valid) begin
        checkOutput($sformatf("bp_word%0d", outIdx), 32'(saida), 32'(bpData[outIdx]));
        outIdx++;
      end
      accept = in_valid && in_ready;
      @(posedge clk);
      if (accept) acc++;
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("bp_delivered", 32'(outIdx), 32'd4);
    checkOutput("bp_cont", 32'(cont_erros), 32'd1);

    // Reset with two words in flight.
    in_valid = 1'b1;
    entrada  = 15'h7FEF;
    step();
    entrada  = 15'h0006;
    step();
    in_valid = 1'b0;
    checkOutput("mid_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_cont",  32'(cont_erros), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    checkOutput("mid_rel_ready", 32'(in_ready), 32'd1);
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (out_valid) stale++;
    end
    checkOutput("no_stale", 32'(stale), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
